// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter sharing one memory port between fetch and data.
// Optional fetch-starvation guard: define MEMARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
   parameter int AW           = 32,
   parameter int DW           = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic [DW-1:0] if_rdata,
   output logic          if_valid,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic [DW-1:0] d_rdata,
   output logic          d_valid,
   output logic          m_req,
   output logic          m_we,
   output logic [AW-1:0] m_addr,
   output logic [DW-1:0] m_wdata,
   input  logic [DW-1:0] m_rdata,
   input  logic          m_ready,
   output logic          stall
);

   typedef enum logic [1:0] {
      IDLE,
      GNT_I,
      GNT_D
   } state_t;

   state_t state;
   state_t state_nx;

   logic arb;
   logic pick_d;
   logic pick_i;
   logic done_i;
   logic done_d;

   // Arbitrate only in a quiet IDLE cycle: a completion pulse means the
   // finishing requester is releasing or re-presenting, so no grant is made.
   assign arb = (state == IDLE) & ~if_valid & ~d_valid;

   assign done_i = (state == GNT_I) & m_ready;
   assign done_d = (state == GNT_D) & m_ready;

`ifdef MEMARB_STARVE_GUARD_EN
   localparam int CW = $clog2(STARVE_LIMIT + 1);

   logic [CW-1:0] starve;
   logic          force_i;

   assign force_i = if_req & (starve == CW'(STARVE_LIMIT));

   // Data priority unless the fetch has lost STARVE_LIMIT times in a row.
   always_comb begin
      pick_d = arb & d_req & ~force_i;
      pick_i = arb & if_req & ~pick_d;
   end

   // Saturating count of consecutive arbitrations a waiting fetch lost.
   always_ff @(posedge clk) begin
      if (reset) begin
         starve <= '0;
      end else if (pick_i) begin
         starve <= '0;
      end else if (pick_d) begin
         if (!if_req)
            starve <= '0;
         else if (starve != CW'(STARVE_LIMIT))
            starve <= starve + CW'(1);
      end
   end
`else
   // Fixed priority: the data access belongs to the older instruction.
   always_comb begin
      pick_d = arb & d_req;
      pick_i = arb & if_req & ~d_req;
   end
`endif

   // Next-state logic of the grant FSM.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (pick_d)
               state_nx = GNT_D;
            else if (pick_i)
               state_nx = GNT_I;
         end
         GNT_I: begin
            if (m_ready)
               state_nx = IDLE;
         end
         GNT_D: begin
            if (m_ready)
               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // Memory-side request registers, held steady for the whole grant.
   always_ff @(posedge clk) begin
      if (reset) begin
         m_req   <= 1'b0;
         m_we    <= 1'b0;
         m_addr  <= '0;
         m_wdata <= '0;
      end else if (pick_d) begin
         m_req   <= 1'b1;
         m_we    <= d_we;
         m_addr  <= d_addr;
         m_wdata <= d_wdata;
      end else if (pick_i) begin
         m_req   <= 1'b1;
         m_we    <= 1'b0;
         m_addr  <= if_addr;
      end else if (done_i | done_d) begin
         m_req   <= 1'b0;
         m_we    <= 1'b0;
      end
   end

   // Completion pulses and read-data capture; stores leave d_rdata alone.
   always_ff @(posedge clk) begin
      if (reset) begin
         if_valid <= 1'b0;
         d_valid  <= 1'b0;
         if_rdata <= '0;
         d_rdata  <= '0;
      end else begin
         if_valid <= done_i;
         d_valid  <= done_d;
         if (done_i)
            if_rdata <= m_rdata;
         if (done_d && !m_we)
            d_rdata <= m_rdata;
      end
   end

   assign stall = (if_req & ~if_valid) | (d_req & ~d_valid);

endmodule
